// File: rtl/muldiv_sequencer_pkg.sv
// Shared types for the M-extension sequencer: funct3 op encoding, FSM states,
// default latencies and the divide result pair.
package MulDivTypes;

   localparam int DEFAULT_XLEN        = 32;
   localparam int DEFAULT_MUL_LATENCY = 2;
   localparam int DEFAULT_DIV_ITERS   = 32;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } MulDivOp;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } MulDivState;

   typedef struct packed {
      logic [DEFAULT_XLEN-1:0] quotient;
      logic [DEFAULT_XLEN-1:0] remainder;
   } MulDivResult;

endpackage

// File: rtl/muldiv_sequencer_divider.sv
// Restoring radix-2 divider datapath on unsigned magnitudes; the caller owns
// the iteration count. quotient/remainder show the values after the current step.
module muldiv_divider_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            step,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder
);

   logic [XLEN-1:0] quoReg;
   logic [XLEN-1:0] remReg;
   logic [XLEN-1:0] dvsReg;
   logic [XLEN:0]   shifted;
   logic [XLEN:0]   diff;

   // Partial remainder stays below the divisor, so diff's top bit is the borrow.
   always_comb begin
      shifted = {remReg, quoReg[XLEN-1]};
      diff    = shifted - {1'b0, dvsReg};
      if (diff[XLEN]) begin
         remainder = shifted[XLEN-1:0];
         quotient  = {quoReg[XLEN-2:0], 1'b0};
      end else begin
         remainder = diff[XLEN-1:0];
         quotient  = {quoReg[XLEN-2:0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         quoReg <= '0;
         remReg <= '0;
         dvsReg <= '0;
      end else if (start) begin
         quoReg <= dividend;
         remReg <= '0;
         dvsReg <= divisor;
      end else if (step) begin
         quoReg <= quotient;
         remReg <= remainder;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Execute-stage MUL/DIV sequencer: latency-counted multiply, iterative divide.
// Optional divide result cache enabled by defining MULDIV_RESULT_CACHE_EN.
module muldiv_sequencer
   import MulDivTypes::*;
#(
   parameter int XLEN        = DEFAULT_XLEN,
   parameter int MUL_LATENCY = DEFAULT_MUL_LATENCY,
   parameter int DIV_ITERS   = DEFAULT_DIV_ITERS
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   input  logic            stall,
   output logic            busy,
   output logic            resultValid,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(DIV_ITERS > MUL_LATENCY ? DIV_ITERS : MUL_LATENCY);

   MulDivState      state, stateNext;
   logic [2:0]      opReg;
   logic [XLEN-1:0] aReg, bReg;
   logic            negQReg, negRReg;
   logic [CNT_W-1:0] cnt, cntNext;
   logic [XLEN-1:0] resultReg, resultNext;
   logic            accept, divStart, divStep, resultLoad;
   logic            isSigned, isRem, divByZero, overflow;
   logic [XLEN-1:0] absA, absB, specialResult;
   logic [XLEN-1:0] stepQuot, stepRem, fixQuot, fixRem;

   function automatic logic [XLEN-1:0] mulSelect(input logic [2:0] f,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
      logic signed [2*XLEN-1:0] ea, eb, p;
      ea = $signed({{XLEN{(f == OP_MULH || f == OP_MULHSU) && a[XLEN-1]}}, a});
      eb = $signed({{XLEN{(f == OP_MULH) && b[XLEN-1]}}, b});
      p  = ea * eb;
      return (f == OP_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
   endfunction

   assign isSigned  = ~op[0];
   assign isRem     = op[1];
   assign divByZero = (rs2 == '0);
   assign overflow  = isSigned && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
   assign absA      = (isSigned && rs1[XLEN-1]) ? -rs1 : rs1;
   assign absB      = (isSigned && rs2[XLEN-1]) ? -rs2 : rs2;
   // Overflow DIV returns the dividend itself, so rs1 covers both special DIV/REM paths.
   assign specialResult = divByZero ? (isRem ? rs1 : '1) : (isRem ? '0 : rs1);

   muldiv_divider_core #(.XLEN(XLEN)) divCore (
      .clk      (clk),
      .rst      (rst),
      .start    (divStart),
      .step     (divStep),
      .dividend (absA),
      .divisor  (absB),
      .quotient (stepQuot),
      .remainder(stepRem)
   );

   assign fixQuot = negQReg ? -stepQuot : stepQuot;
   assign fixRem  = negRReg ? -stepRem : stepRem;

`ifdef MULDIV_RESULT_CACHE_EN
   logic            cacheValid, cacheSigned, cacheHit, cacheWrite, cacheKill;
   logic [XLEN-1:0] cacheA, cacheB;
   MulDivResult     cacheData;

   assign cacheHit = cacheValid && (cacheA == rs1) && (cacheB == rs2) && (cacheSigned == isSigned);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cacheValid  <= 1'b0;
         cacheSigned <= 1'b0;
         cacheA      <= '0;
         cacheB      <= '0;
         cacheData   <= '0;
      end else if (cacheKill) begin
         cacheValid <= 1'b0;
      end else if (cacheWrite) begin
         cacheValid  <= 1'b1;
         cacheSigned <= ~opReg[0];
         cacheA      <= aReg;
         cacheB      <= bReg;
         cacheData   <= '{quotient: fixQuot, remainder: fixRem};
      end
   end
`endif

   always_comb begin
      stateNext   = state;
      cntNext     = cnt;
      busy        = 1'b0;
      resultValid = 1'b0;
      accept      = 1'b0;
      divStart    = 1'b0;
      divStep     = 1'b0;
      resultLoad  = 1'b0;
      resultNext  = '0;
`ifdef MULDIV_RESULT_CACHE_EN
      cacheWrite  = 1'b0;
      cacheKill   = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (req) begin
               accept = 1'b1;
               busy   = 1'b1;
               if (!op[2]) begin
                  if (MUL_LATENCY == 1) begin
                     stateNext  = S_DONE;
                     resultLoad = 1'b1;
                     resultNext = mulSelect(op, rs1, rs2);
                  end else begin
                     stateNext = S_MUL;
                     cntNext   = CNT_W'(MUL_LATENCY - 1);
                  end
               end else if (divByZero || overflow) begin
                  stateNext  = S_DONE;
                  resultLoad = 1'b1;
                  resultNext = specialResult;
`ifdef MULDIV_RESULT_CACHE_EN
               end else if (cacheHit) begin
                  stateNext  = S_DONE;
                  resultLoad = 1'b1;
                  resultNext = isRem ? cacheData.remainder : cacheData.quotient;
`endif
               end else begin
                  stateNext = S_DIV;
                  divStart  = 1'b1;
                  cntNext   = CNT_W'(DIV_ITERS - 1);
               end
            end
         end
         S_MUL: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) begin
               stateNext  = S_DONE;
               resultLoad = 1'b1;
               resultNext = mulSelect(opReg, aReg, bReg);
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         S_DIV: begin
            busy    = 1'b1;
            divStep = 1'b1;
            if (cnt == '0) begin
               stateNext  = S_DONE;
               resultLoad = 1'b1;
               resultNext = opReg[1] ? fixRem : fixQuot;
`ifdef MULDIV_RESULT_CACHE_EN
               cacheWrite = 1'b1;
`endif
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         S_DONE: begin
            resultValid = 1'b1;
            if (!stall) stateNext = S_IDLE;
         end
         default: stateNext = S_IDLE;
      endcase
      // Flush overrides everything above, including a same-cycle request.
      if (flush) begin
         stateNext   = S_IDLE;
         busy        = 1'b0;
         resultValid = 1'b0;
         accept      = 1'b0;
         divStart    = 1'b0;
         divStep     = 1'b0;
         resultLoad  = 1'b0;
`ifdef MULDIV_RESULT_CACHE_EN
         cacheWrite  = 1'b0;
         cacheKill   = (state == S_DIV);
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= stateNext;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         opReg     <= '0;
         aReg      <= '0;
         bReg      <= '0;
         negQReg   <= 1'b0;
         negRReg   <= 1'b0;
         cnt       <= '0;
         resultReg <= '0;
      end else begin
         cnt <= cntNext;
         if (accept) begin
            opReg   <= op;
            aReg    <= rs1;
            bReg    <= rs2;
            negQReg <= isSigned && (rs1[XLEN-1] ^ rs2[XLEN-1]);
            negRReg <= isSigned && rs1[XLEN-1];
         end
         if (resultLoad) resultReg <= resultNext;
      end
   end

   assign result = resultReg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed ops push expected result and
// latency; a negedge monitor checks each new resultValid against the queue.
module tb_muldiv_sequencer;

   localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
   localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;
   localparam int MUL_LAT = 2;
   localparam int DIV_LAT = 33;
`ifdef MULDIV_RESULT_CACHE_EN
   localparam int HIT_LAT = 1;
`else
   localparam int HIT_LAT = 33;
`endif

   typedef struct {
      logic [31:0] res;
      int          lat;
      int          acc;
      string       name;
   } ExpEntry;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req = 1'b0;
   logic [2:0]  op = '0;
   logic [31:0] rs1 = '0, rs2 = '0;
   logic        flush = 1'b0, stall = 1'b0;
   logic        busy, resultValid;
   logic [31:0] result;

   int      tests = 0;
   int      fails = 0;
   int      cyc = 0;
   logic    prevValid = 1'b0;
   ExpEntry sb[$];

   muldiv_sequencer #(.XLEN(32), .MUL_LATENCY(2), .DIV_ITERS(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .op         (op),
      .rs1        (rs1),
      .rs2        (rs2),
      .flush      (flush),
      .stall      (stall),
      .busy       (busy),
      .resultValid(resultValid),
      .result     (result)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: compare once per result, on the first cycle resultValid is seen.
   always @(negedge clk) begin
      if (rst && resultValid && !prevValid) begin
         tests++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_result: got resultValid with %h, required no result", result);
         end else begin
            ExpEntry e;
            e = sb.pop_front();
            if (result !== e.res) begin
               fails++;
               $display("FAIL %s result: got %h required %h", e.name, result, e.res);
            end
            tests++;
            if (cyc - e.acc != e.lat) begin
               fails++;
               $display("FAIL %s latency: got %0d required %0d", e.name, cyc - e.acc, e.lat);
            end
         end
      end
      prevValid = resultValid;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s: got %h required %h", name, got, want);
      end
   endtask

   // Present an op for one cycle and return once the acceptance cycle is sampled.
   task automatic present(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string name);
      @(posedge clk); #1;
      req = 1'b1; op = f; rs1 = a; rs2 = b;
      @(negedge clk);
      check({name, "_accept_busy"}, {31'b0, busy}, 32'd1);
   endtask

   task automatic scramble();
      req = 1'b0; op = 3'($urandom); rs1 = $urandom; rs2 = $urandom;
   endtask

   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expRes, input int expLat, input string name);
      int busyCnt;
      bit seen;
      ExpEntry e;
      present(f, a, b, name);
      e.res = expRes; e.lat = expLat; e.acc = cyc; e.name = name;
      sb.push_back(e);
      busyCnt = 1;
      seen = 1'b0;
      @(posedge clk); #1;
      scramble();
      for (int i = 0; i < 100 && !seen; i++) begin
         @(negedge clk);
         if (resultValid) seen = 1'b1;
         else if (busy) busyCnt++;
      end
      tests++;
      if (!seen) begin
         fails++;
         $display("FAIL %s timeout: got no resultValid required one within 100 cycles", name);
      end else if (busyCnt != expLat) begin
         fails++;
         $display("FAIL %s busy_cycles: got %0d required %0d", name, busyCnt, expLat);
      end
   endtask

   // Start an op that is flushed n cycles after acceptance; nothing is scoreboarded.
   task automatic startAndFlush(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                                input int n, input string name);
      present(f, a, b, name);
      @(posedge clk); #1;
      scramble();
      repeat (n - 1) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check({name, "_flush_busy"}, {31'b0, busy}, 32'd0);
      check({name, "_flush_valid"}, {31'b0, resultValid}, 32'd0);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check({name, "_after_busy"}, {31'b0, busy}, 32'd0);
      repeat (40) @(negedge clk);
      check({name, "_never_valid"}, {31'b0, resultValid}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_valid", {31'b0, resultValid}, 32'd0);
      check("reset_result", result, 32'd0);
      #2 rst = 1'b1;

      issue(F_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, MUL_LAT, "mulhsu");
      issue(F_MULH,   32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, MUL_LAT, "mulh");
      issue(F_MULHU,  32'h8000_0000, 32'h0000_0004, 32'h0000_0002, MUL_LAT, "mulhu");
      issue(F_MUL,    32'h0000_0003, 32'h0000_0004, 32'h0000_000C, MUL_LAT, "mul");
      issue(F_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, DIV_LAT, "div_neg");
      issue(F_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, HIT_LAT, "rem_neg");
      issue(F_DIVU,   32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 1, "divu_by0");
      issue(F_REMU,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1, "remu_by0");
      issue(F_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
      issue(F_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");

      // Reset mid-divide: the op is lost and outputs clear immediately.
      present(F_DIV, 32'd1000, 32'd3, "reset_mid");
      @(posedge clk); #1;
      scramble();
      repeat (4) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("reset_mid_busy", {31'b0, busy}, 32'd0);
      check("reset_mid_result", result, 32'd0);
      @(negedge clk); #2 rst = 1'b1;
      issue(F_MUL, 32'd7, 32'd6, 32'd42, MUL_LAT, "mul_after_reset");

      startAndFlush(F_DIV, 32'd1000, 32'd3, 10, "div_flush");
      issue(F_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, "mul_after_flush");

      // Flush together with req: nothing is accepted.
      @(posedge clk); #1;
      req = 1'b1; op = F_MUL; rs1 = 32'd9; rs2 = 32'd9; flush = 1'b1;
      @(negedge clk);
      check("flush_req_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      req = 1'b0; flush = 1'b0;
      repeat (4) @(negedge clk);
      check("flush_req_no_result", {31'b0, resultValid}, 32'd0);

      // Stall in DONE with req held: result held, then exactly one new op accepted.
      present(F_MUL, 32'd5, 32'd6, "stall_mul");
      begin
         ExpEntry e;
         e.res = 32'd30; e.lat = MUL_LAT; e.acc = cyc; e.name = "stall_mul";
         sb.push_back(e);
      end
      stall = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_valid", {31'b0, resultValid}, 32'd1);
         check("stall_result", result, 32'd30);
         check("stall_busy", {31'b0, busy}, 32'd0);
         @(posedge clk); #1;
      end
      stall = 1'b0;
      @(negedge clk);
      check("stall_release_valid", {31'b0, resultValid}, 32'd1);
      @(posedge clk); #1;
      op = F_MULHU; rs1 = 32'hFFFF_FFFF; rs2 = 32'hFFFF_FFFF;
      @(negedge clk);
      check("stall_next_accept", {31'b0, busy}, 32'd1);
      begin
         ExpEntry e;
         e.res = 32'hFFFF_FFFE; e.lat = MUL_LAT; e.acc = cyc; e.name = "after_stall";
         sb.push_back(e);
      end
      @(posedge clk); #1;
      scramble();
      repeat (4) @(negedge clk);
      check("after_stall_idle", {31'b0, busy}, 32'd0);

      // Divide result cache behaviour (full latency when the cache is absent).
      issue(F_DIV,  32'd100, 32'd7, 32'd14, DIV_LAT, "div_100_7");
      issue(F_REM,  32'd100, 32'd7, 32'd2,  HIT_LAT, "rem_100_7");
      issue(F_MUL,  32'd3,   32'd4, 32'd12, MUL_LAT, "mul_between");
      issue(F_DIV,  32'd100, 32'd7, 32'd14, HIT_LAT, "div_100_7_again");
      issue(F_DIVU, 32'd100, 32'd7, 32'd14, DIV_LAT, "divu_100_7");
      startAndFlush(F_DIVU, 32'd50, 32'd5, 5, "divu_flush");
      issue(F_REMU, 32'd100, 32'd7, 32'd2,  DIV_LAT, "remu_after_kill");

      repeat (5) @(negedge clk);
      check("scoreboard_empty", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
